acc_multiblock_ctrl: RTL and testbench

// - Parametrised control FSM for the SHA-256 accelerator; drives Message Scheduler (MS) and Compressor (CM).
// - Hashes NUM_BLOCKS 512-bit blocks read from the HCB and writes the digest back to the ACB in a counted loop.
// - Optional nonce-sweep mode rehashes with nonce+1 until the digest meets a leading-zero target.
// - Supports a CPU abort. Sits between the MMIO listen path, the memory arbiter, and the MS/CM datapath.

---
 rtl/acc_pkg.sv | 32 +++
 rtl/acc_word_writer.sv | 48 ++++
 rtl/acc_multiblock_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_acc_multiblock_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and status/control bit positions for the SHA-256 accelerator controller.
// Also used by the host driver model.
package acc_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StWrBusy,
      StRdBlk,
      StInit,
      StUpd1,
      StHash,
      StUpd2,
      StCheck,
      StWrHash,
      StWrDone
   } state_t;

   localparam int unsigned STATUS_DONE  = 1;
   localparam int unsigned STATUS_BUSY  = 2;
   localparam int unsigned STATUS_ERR   = 3;
   localparam int unsigned STATUS_FOUND = 4;
   localparam int unsigned STATUS_W     = 5;

   localparam int unsigned CTRL_START = 0;
   localparam int unsigned CTRL_SWEEP = 1;

   // Mask covering the top z bits of a digest; z == 0 gives an empty mask.
   function automatic logic [255:0] lead_mask(input logic [5:0] z);
      return ~({256{1'b1}} >> z);
   endfunction

endpackage

// File: rtl/acc_word_writer.sv
// Writes a 256-bit digest as consecutive DATA_W-bit words starting at BASE_ADDR.
// A word advances only when its write is accepted; stop abandons the loop.
module acc_word_writer #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h5008
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              wr_done,
   input  logic [255:0]      digest,
   output logic              last,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   localparam int unsigned NUM_WORDS = 256 / DATA_W;
   localparam int unsigned IDX_W = $clog2(NUM_WORDS + 1);

   logic             busy_q;
   logic [IDX_W-1:0] idx_q;
   logic [8:0]       bit_off;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         idx_q  <= '0;
      end else if (start) begin
         busy_q <= 1'b1;
         idx_q  <= '0;
      end else if (busy_q && (stop || (wr_done && last))) begin
         busy_q <= 1'b0;
         idx_q  <= '0;
      end else if (busy_q && wr_done) begin
         idx_q <= idx_q + 1'b1;
      end
   end

   assign last    = busy_q && (idx_q == IDX_W'(NUM_WORDS - 1));
   assign bit_off = 9'(idx_q) * 9'(DATA_W);
   assign wr_en   = busy_q;
   assign wr_addr = BASE_ADDR + ADDR_W'(idx_q) * ADDR_W'(DATA_W);
   assign wr_data = digest[bit_off +: DATA_W];

endmodule

// File: rtl/acc_multiblock_ctrl.sv
// Control FSM for the SHA-256 accelerator: reads NUM_BLOCKS blocks, sequences MS/CM,
// optionally sweeps the nonce against a leading-zero target, and writes digest and status.
module acc_multiblock_ctrl
   import acc_pkg::*;
#(
   parameter int unsigned MEM_LISTEN_ADDR_SIZE = 16,
   parameter int unsigned MEM_LISTEN_DATA_SIZE = 32,
   parameter int unsigned MEM_ADDR_SIZE        = 16,
   parameter int unsigned MEM_READ_DATA_SIZE   = 512,
   parameter int unsigned MEM_WRITE_DATA_SIZE  = 32,
   parameter int unsigned NUM_BLOCKS           = 3,
   parameter int unsigned ROUNDS               = 64,
   parameter logic [MEM_ADDR_SIZE-1:0] HCB_START_ADDR = 16'h1000,
   parameter logic [MEM_ADDR_SIZE-1:0] ACB_START_ADDR = 16'h5000,
   parameter logic [MEM_ADDR_SIZE-1:0] ACB_H0_OFFSET  = 16'h0008,
   parameter int unsigned NONCE_W              = 32,
   parameter int unsigned MAX_PASSES           = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              mem_listen_en,
   input  logic [MEM_LISTEN_ADDR_SIZE-1:0]   mem_listen_addr,
   input  logic [MEM_LISTEN_DATA_SIZE-1:0]   mem_listen_data,
   output logic                              rd_en,
   output logic [MEM_ADDR_SIZE-1:0]          rd_addr,
   input  logic                              rd_valid,
   output logic                              wr_en,
   output logic [MEM_ADDR_SIZE-1:0]          wr_addr,
   output logic [MEM_WRITE_DATA_SIZE-1:0]    wr_data,
   input  logic                              wr_done,
   input  logic [255:0]                      cm_out,
   output logic                              ms_init,
   output logic                              ms_enable,
   output logic                              cm_rst_hash_n,
   output logic                              cm_update_A_H,
   output logic                              cm_is_hashing,
   output logic                              cm_update_H0_7,
   output logic [$clog2(ROUNDS):0]           cm_cycle_count,
   output logic [$clog2(NUM_BLOCKS):0]       msg_sel,
   output logic [NONCE_W-1:0]                nonce,
   output logic                              hash_done
);

   localparam int unsigned CC_W   = $clog2(ROUNDS) + 1;
   localparam int unsigned BLK_W  = $clog2(NUM_BLOCKS) + 1;
   localparam int unsigned PASS_W = $clog2(MAX_PASSES + 1);

   state_t              state_q;
   logic [CC_W-1:0]     round_q;
   logic [BLK_W-1:0]    blk_q;
   logic [PASS_W-1:0]   passes_q;
   logic [PASS_W-1:0]   passes_nxt;
   logic [NONCE_W-1:0]  nonce_q;
   logic [5:0]          zt_q;
   logic                sweep_q, err_q, found_q;

   logic ctrl_hit, start_wr, abort_wr, aborting, met, more_passes, last_blk;
   logic ww_start, ww_stop, ww_last, ww_en;
   logic [MEM_ADDR_SIZE-1:0]       ww_addr;
   logic [MEM_WRITE_DATA_SIZE-1:0] ww_data;
   logic [STATUS_W-1:0]            status;
   logic                           unused_bits;

   assign ctrl_hit    = mem_listen_en
                        && (mem_listen_addr == MEM_LISTEN_ADDR_SIZE'(ACB_START_ADDR));
   assign start_wr    = ctrl_hit && mem_listen_data[CTRL_START];
   assign abort_wr    = ctrl_hit && !mem_listen_data[CTRL_START];
   assign aborting    = err_q || abort_wr;
   assign met         = (cm_out & lead_mask(zt_q)) == '0;
   assign passes_nxt  = passes_q + 1'b1;
   assign more_passes = passes_nxt < PASS_W'(MAX_PASSES);
   assign last_blk    = blk_q == BLK_W'(NUM_BLOCKS - 1);
   assign ww_start    = (state_q == StCheck) && !aborting && (!sweep_q || met || !more_passes);
   assign ww_stop     = (state_q == StWrHash) && aborting && wr_done;
   assign unused_bits = ^mem_listen_data[MEM_LISTEN_DATA_SIZE-1:8];

   acc_word_writer #(
      .ADDR_W   (MEM_ADDR_SIZE),
      .DATA_W   (MEM_WRITE_DATA_SIZE),
      .BASE_ADDR(ACB_START_ADDR + ACB_H0_OFFSET)
   ) u_writer (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (ww_start),
      .stop   (ww_stop),
      .wr_done(wr_done),
      .digest (cm_out),
      .last   (ww_last),
      .wr_en  (ww_en),
      .wr_addr(ww_addr),
      .wr_data(ww_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         round_q  <= '0;
         blk_q    <= '0;
         passes_q <= '0;
         nonce_q  <= '0;
         zt_q     <= '0;
         sweep_q  <= 1'b0;
         err_q    <= 1'b0;
         found_q  <= 1'b0;
      end else begin
         if (abort_wr && state_q != StIdle && state_q != StWrDone) err_q <= 1'b1;
         // Abort never cuts an open request short: RD_BLK, WR_BUSY and WR_HASH wait for the grant.
         unique case (state_q)
            StIdle: if (start_wr) begin
               state_q  <= StWrBusy;
               sweep_q  <= mem_listen_data[CTRL_SWEEP];
               zt_q     <= mem_listen_data[7:2];
               nonce_q  <= '0;
               passes_q <= '0;
               blk_q    <= '0;
               round_q  <= '0;
               err_q    <= 1'b0;
               found_q  <= 1'b0;
            end
            StWrBusy: if (wr_done) begin
               blk_q   <= '0;
               state_q <= aborting ? StWrDone : StRdBlk;
            end
            StRdBlk: if (rd_valid) begin
               if (aborting) state_q <= StWrDone;
               else          state_q <= (blk_q == '0) ? StInit : StUpd1;
            end
            StInit: state_q <= aborting ? StWrDone : StUpd1;
            StUpd1: state_q <= aborting ? StWrDone : StHash;
            StHash: begin
               if (aborting) begin
                  round_q <= '0;
                  state_q <= StWrDone;
               end else if (round_q == CC_W'(ROUNDS)) begin
                  round_q <= '0;
                  state_q <= StUpd2;
               end else begin
                  round_q <= round_q + 1'b1;
               end
            end
            StUpd2: begin
               if (aborting)      state_q <= StWrDone;
               else if (last_blk) state_q <= StCheck;
               else begin
                  blk_q   <= blk_q + 1'b1;
                  state_q <= StRdBlk;
               end
            end
            StCheck: begin
               if (aborting) state_q <= StWrDone;
               else if (!sweep_q || met || !more_passes) begin
                  found_q <= sweep_q && met;
                  state_q <= StWrHash;
               end else begin
                  nonce_q  <= nonce_q + 1'b1;
                  passes_q <= passes_nxt;
                  blk_q    <= '0;
                  state_q  <= StRdBlk;
               end
            end
            StWrHash: if (wr_done && (aborting || ww_last)) state_q <= StWrDone;
            StWrDone: if (wr_done) state_q <= StIdle;
            default:  state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      status                 = '0;
      status[STATUS_DONE]    = 1'b1;
      status[STATUS_ERR]     = err_q;
      status[STATUS_FOUND]   = found_q && !err_q;
      rd_en          = 1'b0;
      rd_addr        = '0;
      wr_en          = 1'b0;
      wr_addr        = '0;
      wr_data        = '0;
      ms_init        = 1'b0;
      ms_enable      = 1'b0;
      cm_rst_hash_n  = 1'b1;
      cm_update_A_H  = 1'b0;
      cm_is_hashing  = 1'b0;
      cm_update_H0_7 = 1'b0;
      hash_done      = 1'b0;
      cm_cycle_count = (state_q == StIdle) ? '0 : round_q;
      msg_sel        = (state_q == StIdle) ? '0 : blk_q;
      nonce          = (state_q == StIdle) ? '0 : nonce_q;
      unique case (state_q)
         StWrBusy: begin
            wr_en   = 1'b1;
            wr_addr = ACB_START_ADDR;
            wr_data = MEM_WRITE_DATA_SIZE'(1 << STATUS_BUSY);
         end
         StRdBlk: begin
            rd_en   = 1'b1;
            rd_addr = HCB_START_ADDR
                      + MEM_ADDR_SIZE'(blk_q) * MEM_ADDR_SIZE'(MEM_READ_DATA_SIZE);
         end
         StInit: cm_rst_hash_n = 1'b0;
         StUpd1: begin
            cm_update_A_H = 1'b1;
            ms_init       = 1'b1;
         end
         StHash: begin
            ms_enable     = 1'b1;
            cm_is_hashing = 1'b1;
         end
         StUpd2: cm_update_H0_7 = 1'b1;
         StWrHash: begin
            wr_en   = ww_en;
            wr_addr = ww_addr;
            wr_data = ww_data;
         end
         StWrDone: begin
            wr_en     = 1'b1;
            wr_addr   = ACB_START_ADDR;
            wr_data   = MEM_WRITE_DATA_SIZE'(status);
            hash_done = wr_done;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_acc_multiblock_ctrl.sv
// Directed bench for acc_multiblock_ctrl: arbiter model with configurable grant latency,
// nonce-dependent digest source, and per-scenario checks of the transaction log.
module tb_acc_multiblock_ctrl;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         mem_listen_en = 1'b0;
   logic [15:0]  mem_listen_addr = '0;
   logic [31:0]  mem_listen_data = '0;
   logic         rd_en, wr_en;
   logic [15:0]  rd_addr, wr_addr;
   logic         rd_valid = 1'b0, wr_done = 1'b0;
   logic [31:0]  wr_data;
   logic [255:0] cm_out;
   logic         ms_init, ms_enable, cm_rst_hash_n, cm_update_A_H, cm_is_hashing, cm_update_H0_7;
   logic [6:0]   cm_cycle_count;
   logic [2:0]   msg_sel;
   logic [31:0]  nonce;
   logic         hash_done;

   int total = 0, bad = 0;
   int lat = 0, rd_wait = 0, wr_wait = 0;
   int hash_cyc, rst_cyc, upd_ah, upd_h0, hd_cnt, stab_err;
   logic [31:0] nonce_done;
   logic [31:0] tgt_nonce = 32'hFFFF_FFFF;
   logic [15:0] rd_log[$];
   logic [15:0] wa_log[$];
   logic [31:0] wd_log[$];
   logic        rd_hold = 1'b0, wr_hold = 1'b0;
   logic [15:0] rd_prev, wa_prev;
   logic [31:0] wd_prev;

   always #5 clk = ~clk;

   acc_multiblock_ctrl #(.MAX_PASSES(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_listen_en  (mem_listen_en),
      .mem_listen_addr(mem_listen_addr),
      .mem_listen_data(mem_listen_data),
      .rd_en          (rd_en),
      .rd_addr        (rd_addr),
      .rd_valid       (rd_valid),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_done        (wr_done),
      .cm_out         (cm_out),
      .ms_init        (ms_init),
      .ms_enable      (ms_enable),
      .cm_rst_hash_n  (cm_rst_hash_n),
      .cm_update_A_H  (cm_update_A_H),
      .cm_is_hashing  (cm_is_hashing),
      .cm_update_H0_7 (cm_update_H0_7),
      .cm_cycle_count (cm_cycle_count),
      .msg_sel        (msg_sel),
      .nonce          (nonce),
      .hash_done      (hash_done)
   );

   // Digest stand-in: top word has its two MSBs clear only at the target nonce.
   function automatic logic [255:0] dig(input logic [31:0] n, input logic [31:0] t);
      logic [255:0] d;
      logic [31:0]  w;
      for (int i = 0; i < 8; i++) begin
         w = 32'h1111_1111 * (i + 1) + n;
         if (i == 7 && n == t) w = 32'h3000_0000 | n;
         d[i*32 +: 32] = w;
      end
      return d;
   endfunction

   assign cm_out = dig(nonce, tgt_nonce);

   // Arbiter: grant after lat stalled cycles, then log and sample 1 time unit later.
   always @(negedge clk) begin
      if (rd_en) begin
         if (rd_wait >= lat) begin rd_valid = 1'b1; rd_wait = 0; end
         else begin rd_valid = 1'b0; rd_wait++; end
      end else begin
         rd_valid = 1'b0; rd_wait = 0;
      end
      if (wr_en) begin
         if (wr_wait >= lat) begin wr_done = 1'b1; wr_wait = 0; end
         else begin wr_done = 1'b0; wr_wait++; end
      end else begin
         wr_done = 1'b0; wr_wait = 0;
      end
      #1;
      if (rd_en && rd_valid) rd_log.push_back(rd_addr);
      if (wr_en && wr_done) begin wa_log.push_back(wr_addr); wd_log.push_back(wr_data); end
      if (rd_en && !rd_valid) begin
         if (rd_hold && rd_addr !== rd_prev) stab_err++;
         rd_hold = 1'b1; rd_prev = rd_addr;
      end else rd_hold = 1'b0;
      if (wr_en && !wr_done) begin
         if (wr_hold && (wr_addr !== wa_prev || wr_data !== wd_prev)) stab_err++;
         wr_hold = 1'b1; wa_prev = wr_addr; wd_prev = wr_data;
      end else wr_hold = 1'b0;
      if (cm_is_hashing) hash_cyc++;
      if (!cm_rst_hash_n) rst_cyc++;
      if (cm_update_A_H) upd_ah++;
      if (cm_update_H0_7) upd_h0++;
      if (hash_done) begin hd_cnt++; nonce_done = nonce; end
   end

   task automatic clear_logs();
      rd_log.delete(); wa_log.delete(); wd_log.delete();
      hash_cyc = 0; rst_cyc = 0; upd_ah = 0; upd_h0 = 0; hd_cnt = 0; stab_err = 0;
      nonce_done = '0;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      mem_listen_en = 1'b1; mem_listen_addr = a; mem_listen_data = d;
      @(negedge clk);
      mem_listen_en = 1'b0; mem_listen_data = '0;
   endtask

   task automatic run_until_done(input int lim);
      for (int c = 0; c < lim && hd_cnt == 0; c++) begin
         @(negedge clk); #2;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      total++;
      if ({rd_en, wr_en, ms_init, ms_enable, cm_update_A_H, cm_is_hashing, cm_update_H0_7,
           hash_done} !== 8'h00) begin
         bad++; $display("FAIL reset_strobes: got %b want 0", {rd_en, wr_en, ms_init});
      end
      total++;
      if (cm_rst_hash_n !== 1'b1) begin
         bad++; $display("FAIL reset_cm_rst_hash_n: got %b want 1", cm_rst_hash_n);
      end
      total++;
      if ({cm_cycle_count, msg_sel, nonce} !== '0) begin
         bad++; $display("FAIL reset_counters: got %0h/%0h/%0h want 0", cm_cycle_count, msg_sel,
                         nonce);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_nominal(input int lt);
      logic [255:0] d;
      d = dig(32'd0, 32'hFFFF_FFFF);
      tgt_nonce = 32'hFFFF_FFFF;
      clear_logs();
      lat = lt;
      cpu_write(16'h5000, 32'h1);
      run_until_done(4000);
      total++;
      if (hd_cnt !== 1) begin bad++; $display("FAIL nom%0d_hash_done: got %0d want 1", lt, hd_cnt); end
      total++;
      if (rd_log.size() !== 3) begin
         bad++; $display("FAIL nom%0d_reads: got %0d want 3", lt, rd_log.size());
      end
      for (int k = 0; k < 3; k++) begin
         total++;
         if (rd_log[k] !== 16'h1000 + 16'(k) * 16'h200) begin
            bad++; $display("FAIL nom%0d_rd_addr%0d: got %0h want %0h", lt, k, rd_log[k],
                            16'h1000 + 16'(k) * 16'h200);
         end
      end
      total++;
      if (hash_cyc !== 195) begin bad++; $display("FAIL nom%0d_hash_cycles: got %0d want 195", lt, hash_cyc); end
      total++;
      if (rst_cyc !== 1 || upd_ah !== 3 || upd_h0 !== 3) begin
         bad++; $display("FAIL nom%0d_cm_pulses: got %0d/%0d/%0d want 1/3/3", lt, rst_cyc, upd_ah,
                         upd_h0);
      end
      total++;
      if (wa_log.size() !== 10) begin
         bad++; $display("FAIL nom%0d_writes: got %0d want 10", lt, wa_log.size());
      end
      total++;
      if (wa_log[0] !== 16'h5000 || wd_log[0] !== 32'h4) begin
         bad++; $display("FAIL nom%0d_busy_status: got %0h/%0h want 5000/4", lt, wa_log[0], wd_log[0]);
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (wa_log[i+1] !== 16'h5008 + 16'(i) * 16'd32 || wd_log[i+1] !== d[i*32 +: 32]) begin
            bad++; $display("FAIL nom%0d_digest%0d: got %0h/%0h want %0h/%0h", lt, i, wa_log[i+1],
                            wd_log[i+1], 16'h5008 + 16'(i) * 16'd32, d[i*32 +: 32]);
         end
      end
      total++;
      if (wa_log[9] !== 16'h5000 || wd_log[9] !== 32'h02) begin
         bad++; $display("FAIL nom%0d_final_status: got %0h/%0h want 5000/2", lt, wa_log[9], wd_log[9]);
      end
      total++;
      if (stab_err !== 0) begin bad++; $display("FAIL nom%0d_req_stable: got %0d want 0", lt, stab_err); end
      lat = 0;
   endtask

   task automatic test_sweep();
      tgt_nonce = 32'd3;
      clear_logs();
      cpu_write(16'h5000, 32'h0B);
      run_until_done(6000);
      total++;
      if (hd_cnt !== 1) begin bad++; $display("FAIL sweep_hash_done: got %0d want 1", hd_cnt); end
      total++;
      if (nonce_done !== 32'd3) begin bad++; $display("FAIL sweep_nonce: got %0d want 3", nonce_done); end
      total++;
      if (rd_log.size() !== 12) begin bad++; $display("FAIL sweep_reads: got %0d want 12", rd_log.size()); end
      total++;
      if (wd_log[8] !== 32'h3000_0003 || wd_log[1] !== 32'h1111_1114) begin
         bad++; $display("FAIL sweep_digest: got %0h/%0h want 30000003/11111114", wd_log[8], wd_log[1]);
      end
      total++;
      if (wd_log[9] !== 32'h12) begin bad++; $display("FAIL sweep_status: got %0h want 12", wd_log[9]); end
   endtask

   task automatic test_sweep_limit();
      tgt_nonce = 32'd100;
      clear_logs();
      cpu_write(16'h5000, 32'h0B);
      run_until_done(6000);
      total++;
      if (hd_cnt !== 1) begin bad++; $display("FAIL limit_hash_done: got %0d want 1", hd_cnt); end
      total++;
      if (nonce_done !== 32'd3) begin bad++; $display("FAIL limit_nonce: got %0d want 3", nonce_done); end
      total++;
      if (rd_log.size() !== 12 || rst_cyc !== 4) begin
         bad++; $display("FAIL limit_passes: got %0d reads %0d inits want 12/4", rd_log.size(), rst_cyc);
      end
      total++;
      if (wd_log[9] !== 32'h02 || wd_log[8] !== 32'h8888_888B) begin
         bad++; $display("FAIL limit_status: got %0h/%0h want 2/8888888b", wd_log[9], wd_log[8]);
      end
   endtask

   task automatic test_abort();
      int seen;
      tgt_nonce = 32'hFFFF_FFFF;
      clear_logs();
      cpu_write(16'h5000, 32'h1);
      seen = 0;
      for (int c = 0; c < 1000 && seen == 0; c++) begin
         @(negedge clk); #2;
         if (msg_sel == 3'd1 && cm_is_hashing && cm_cycle_count == 7'd10) seen = 1;
      end
      total++;
      if (seen !== 1) begin bad++; $display("FAIL abort_reach_blk1: got %0d want 1", seen); end
      cpu_write(16'h5000, 32'h0);
      run_until_done(500);
      total++;
      if (hd_cnt !== 1) begin bad++; $display("FAIL abort_hash_done: got %0d want 1", hd_cnt); end
      total++;
      if (wa_log.size() !== 2 || rd_log.size() !== 2) begin
         bad++; $display("FAIL abort_traffic: got %0d writes %0d reads want 2/2", wa_log.size(),
                         rd_log.size());
      end
      total++;
      if (wa_log[1] !== 16'h5000 || wd_log[1] !== 32'h0A) begin
         bad++; $display("FAIL abort_status: got %0h/%0h want 5000/a", wa_log[1], wd_log[1]);
      end
      @(negedge clk); #2;
      total++;
      if (rd_en !== 1'b0 || wr_en !== 1'b0 || cm_rst_hash_n !== 1'b1 || msg_sel !== 3'd0) begin
         bad++; $display("FAIL abort_idle: got %b%b%b%0d want 0010", rd_en, wr_en, cm_rst_hash_n, msg_sel);
      end
      clear_logs();
      cpu_write(16'h5000, 32'h1);
      run_until_done(4000);
      total++;
      if (hd_cnt !== 1 || wa_log.size() !== 10 || wd_log[9] !== 32'h02) begin
         bad++; $display("FAIL abort_restart: got %0d/%0d/%0h want 1/10/2", hd_cnt, wa_log.size(), wd_log[9]);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      clear_logs();
      cpu_write(16'h5000, 32'h1);
      seen = 0;
      for (int c = 0; c < 2000 && seen == 0; c++) begin
         @(negedge clk); #2;
         if (wr_en && wr_addr == 16'h5088) seen = 1;
      end
      total++;
      if (seen !== 1) begin bad++; $display("FAIL rstmid_reach_word4: got %0d want 1", seen); end
      rst_n = 1'b0;
      @(negedge clk); #2;
      total++;
      if ({rd_en, wr_en, ms_init, ms_enable, cm_update_A_H, cm_is_hashing, cm_update_H0_7,
           hash_done, cm_rst_hash_n} !== 9'b0_0000_0001) begin
         bad++; $display("FAIL rstmid_outputs: got %b%b%b want 001", wr_en, hash_done, cm_rst_hash_n);
      end
      total++;
      if ({cm_cycle_count, msg_sel, nonce, wr_addr, wr_data} !== '0) begin
         bad++; $display("FAIL rstmid_counters: got %0h/%0h/%0h/%0h want 0", cm_cycle_count, msg_sel,
                         nonce, wr_addr);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_nominal(0);
      test_nominal(5);
      test_sweep();
      test_sweep_limit();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
